// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan
//   N-channel, WIDTH-bit multiplexer with a registered output and a
//   valid/ready output handshake.
//   mode=0 (manual): routes the channel named by sel.
//   mode=1 (scan)  : round-robins over enabled channels, one word per load,
//                    acting as a time-division serialiser.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    packed channels, channel k at [k*WIDTH +: WIDTH]
//   ch_en      per-channel enable; disabled channels are never selected
//   mode       0 = manual, 1 = scan
//   sel        manual channel index (values >= N_CH are out of range)
//   out_ready  downstream accepts out_data this cycle
//   out_data   registered selected data
//   out_ch     index of the channel held in out_data
//   out_valid  out_data/out_ch are valid
module mux_nx1_scan #(
    parameter int N_CH  = 7,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         ch_en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid
);

    localparam logic [SEL_W:0]   N_CH_W  = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic [WIDTH-1:0] data_reg, data_next;
    logic [SEL_W-1:0] ch_reg,   ch_next;
    logic             valid_reg, valid_next;
    logic [SEL_W-1:0] ptr_reg,  ptr_next;

    logic [WIDTH-1:0] ch_data [N_CH];
    logic [SEL_W-1:0] rot_idx [N_CH];

    logic             load;
    logic             sel_ok;
    logic             manual_hit;
    logic             scan_hit;
    logic [SEL_W-1:0] scan_idx;

    // Unpack the channel bus and build the search order ptr, ptr+1, ...
    // wrapping at N_CH. ptr < N_CH and gi < N_CH, so a single conditional
    // subtraction is enough for the modulo.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [SEL_W:0] sum;
            assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
            assign sum         = {1'b0, ptr_reg} + (SEL_W+1)'(gi);
            assign rot_idx[gi] = (sum >= N_CH_W) ? SEL_W'(sum - N_CH_W)
                                                 : sum[SEL_W-1:0];
        end
    endgenerate

    // First enabled channel at or after ptr. Walking the offsets from the
    // far end down lets the smallest offset win.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_en[rot_idx[i]]) begin
                scan_hit = 1'b1;
                scan_idx = rot_idx[i];
            end
        end
    end

    // The width-extended compare keeps sel >= N_CH out of range even when
    // N_CH is an exact power of two.
    assign sel_ok     = ({1'b0, sel} < N_CH_W);
    assign manual_hit = sel_ok && ch_en[sel];

    // A held word is never revoked: new inputs are only sampled when the
    // output register is empty or is being consumed this cycle.
    assign load = !valid_reg || out_ready;

    always_comb begin
        data_next  = data_reg;
        ch_next    = ch_reg;
        valid_next = valid_reg;
        ptr_next   = ptr_reg;
        if (load) begin
            if (!mode) begin
                if (manual_hit) begin
                    data_next  = ch_data[sel];
                    ch_next    = sel;
                    valid_next = 1'b1;
                end else begin
                    valid_next = 1'b0;
                end
            end else begin
                if (scan_hit) begin
                    data_next  = ch_data[scan_idx];
                    ch_next    = scan_idx;
                    valid_next = 1'b1;
                    ptr_next   = (scan_idx == LAST_CH) ? '0
                                                       : scan_idx + SEL_W'(1);
                end else begin
                    // Nothing enabled: emit nothing, keep our place.
                    valid_next = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            ch_reg    <= '0;
            valid_reg <= 1'b0;
            ptr_reg   <= '0;
        end else begin
            data_reg  <= data_next;
            ch_reg    <= ch_next;
            valid_reg <= valid_next;
            ptr_reg   <= ptr_next;
        end
    end

    assign out_data  = data_reg;
    assign out_ch    = ch_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Testbench for mux_nx1_scan (N_CH=7, WIDTH=8).
// A reference model advances once per clock edge and queues the output it
// expects; a monitor pops and compares one entry per cycle. Directed
// scenarios add fixed expectations on top; a random phase follows.
module tb_mux_nx1_scan;

    localparam int N_CH  = 7;
    localparam int WIDTH = 8;
    localparam int SEL_W = $clog2(N_CH);

    logic                  clk;
    logic                  rst;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       ch_en;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;

    mux_nx1_scan #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .ch_en(ch_en),
        .mode(mode), .sel(sel), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int valid;
        int data;
        int ch;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   check_cnt = 0;
    int   cycle_cnt = 0;

    task automatic check(input string name, input int act, input int exp_v);
        check_cnt++;
        if (act == exp_v) pass_cnt++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp_v);
    endtask

    // Reference model: the output register as a plain value plus the scan
    // position, searched with modular arithmetic.
    int m_valid = 0, m_data = 0, m_ch = 0, m_ptr = 0;
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
            end else if (m_valid == 0 || out_ready) begin
                if (!mode) begin
                    if (int'(sel) < N_CH && ch_en[sel]) begin
                        m_valid = 1;
                        m_data  = int'(in_data[int'(sel)*WIDTH +: WIDTH]);
                        m_ch    = int'(sel);
                    end else begin
                        m_valid = 0;
                    end
                end else begin
                    int hit;
                    hit = -1;
                    for (int off = 0; off < N_CH; off++) begin
                        int k;
                        k = (m_ptr + off) % N_CH;
                        if (hit < 0 && ch_en[k]) hit = k;
                    end
                    if (hit >= 0) begin
                        m_valid = 1;
                        m_data  = int'(in_data[hit*WIDTH +: WIDTH]);
                        m_ch    = hit;
                        m_ptr   = (hit + 1) % N_CH;
                    end else begin
                        m_valid = 0;
                    end
                end
            end
            exp_q.push_back('{m_valid, m_data, m_ch});
        end
    end

    // Monitor: one line and one scoreboard entry per cycle.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            cycle_cnt++;
            if (exp_q.size() == 0) begin
                check("sb_queue_empty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                $display("cyc %0d: valid=%0d ch=%0d data=%02h ready=%0d",
                         cycle_cnt, out_valid, out_ch, out_data, out_ready);
                check("sb_valid", int'(out_valid), e.valid);
                if (e.valid != 0) begin
                    check("sb_data", int'(out_data), e.data);
                    check("sb_ch", int'(out_ch), e.ch);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic expect_word(input string name, input int v, input int d,
                               input int c);
        check({name, "_valid"}, int'(out_valid), v);
        if (v != 0) begin
            check({name, "_data"}, int'(out_data), d);
            check({name, "_ch"}, int'(out_ch), c);
        end
    endtask

    task automatic set_pattern();
        for (int k = 0; k < N_CH; k++) in_data[k*WIDTH +: WIDTH] = 8'(8'hA0 + k);
    endtask

    initial begin
        int scan_seq[5];
        scan_seq = '{0, 2, 6, 0, 2};

        // 1. reset with random inputs
        rst = 1'b1;
        in_data = {$urandom, $urandom};
        ch_en = 7'($urandom);
        mode = 1'($urandom);
        sel = 3'($urandom);
        out_ready = 1'($urandom);
        cyc();
        cyc();
        check("reset_valid", int'(out_valid), 0);
        check("reset_data", int'(out_data), 0);
        check("reset_ch", int'(out_ch), 0);
        set_pattern();
        rst = 1'b0; mode = 1'b1; ch_en = 7'h7F; out_ready = 1'b1;
        cyc();
        expect_word("first_scan", 1, 'hA0, 0);

        // 2. manual selection
        mode = 1'b0; sel = 3'd5;
        cyc();
        expect_word("manual_sel5", 1, 'hA5, 5);
        sel = 3'd7;
        cyc();
        expect_word("manual_sel7", 0, 0, 0);
        sel = 3'd5; ch_en = 7'h5F;
        cyc();
        expect_word("manual_disabled", 0, 0, 0);

        // 3. full scan with wrap-around, starting from ptr 0
        rst = 1'b1;
        cyc();
        rst = 1'b0; mode = 1'b1; ch_en = 7'h7F;
        for (int i = 0; i < 9; i++) begin
            cyc();
            expect_word("scan_wrap", 1, 'hA0 + (i % N_CH), i % N_CH);
        end

        // 4. sparse enables, then none enabled, then ptr retained
        rst = 1'b1;
        cyc();
        rst = 1'b0; ch_en = 7'b1000101;
        for (int i = 0; i < 5; i++) begin
            cyc();
            expect_word("scan_sparse", 1, 'hA0 + scan_seq[i], scan_seq[i]);
        end
        ch_en = '0;
        cyc();
        expect_word("scan_none", 0, 0, 0);
        ch_en = 7'h7F;
        cyc();
        expect_word("scan_ptr_kept", 1, 'hA3, 3);

        // 5. backpressure while holding ch2
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        cyc();
        expect_word("stall_pre", 1, 'hA2, 2);
        out_ready = 1'b0;
        in_data[2*WIDTH +: WIDTH] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_word("stall_hold", 1, 'hA2, 2);
        end
        out_ready = 1'b1;
        cyc();
        expect_word("stall_release", 1, 'hA3, 3);
        set_pattern();

        // 6. reset with ptr=4, then manual -> scan resumes at retained ptr
        rst = 1'b1;
        cyc();
        expect_word("midrst", 0, 0, 0);
        check("midrst_ch", int'(out_ch), 0);
        rst = 1'b0;
        cyc();
        expect_word("after_rst0", 1, 'hA0, 0);
        cyc();
        expect_word("after_rst1", 1, 'hA1, 1);
        mode = 1'b0; sel = 3'd6;
        cyc();
        expect_word("manual_sel6", 1, 'hA6, 6);
        mode = 1'b1;
        cyc();
        expect_word("resume_scan", 1, 'hA2, 2);

        // Random phase, checked by the scoreboard alone.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 31) == 0);
            in_data = {$urandom, $urandom};
            ch_en = ($urandom_range(0, 7) == 0) ? '0 : 7'($urandom);
            mode = 1'($urandom);
            sel = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        cyc();
        cyc();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
